// File: rtl/synapse_current_accum.sv
// rtl/synapse_current_accum.sv - serial synaptic weight accumulator feeding the LIF neuron current input
//
// Once per timestep, latches a presynaptic spike vector and walks it one synapse per
// cycle, adding the weight of each active synapse into a saturating unsigned current.
//
// Ports:
//   i_clk, i_rst                  clock (rising edge), synchronous active-high reset
//   i_step_start, i_pre_spikes    timestep start pulse and spike vector sampled with it
//   i_w_we, i_w_addr, i_w_data    weight file write port (out-of-range addresses ignored)
//   o_current, o_valid, i_ready   timestep result with valid/ready acknowledge
//   o_busy                        high while scanning or holding an unacknowledged result
//   o_sat                         the last result saturated at all-ones
//   o_overrun                     sticky: a start arrived while busy
//
// Build option: define SYN_DECAY_EN so each timestep starts from the decayed previous
// current (prev - (prev >> TAU_SHIFT)) instead of zero.

module synapse_current_accum #(
    parameter int N_PRE     = 8,
    parameter int WEIGHT_W  = 16,
    parameter int DATA_W    = 32,
    parameter int TAU_SHIFT = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_step_start,
    input  logic [N_PRE-1:0]           i_pre_spikes,
    input  logic                       i_w_we,
    input  logic [$clog2(N_PRE)-1:0]   i_w_addr,
    input  logic [WEIGHT_W-1:0]        i_w_data,
    output logic [DATA_W-1:0]          o_current,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic                       o_busy,
    output logic                       o_sat,
    output logic                       o_overrun
);

    localparam int IDX_W = $clog2(N_PRE);

`ifdef SYN_DECAY_EN
    localparam bit DECAY_EN = 1'b1;
`else
    localparam bit DECAY_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_PRE-1:0]     spikes_q, spikes_d;
    logic [DATA_W-1:0]    acc_q, acc_d;
    logic                 sat_q, sat_d;
    logic [DATA_W-1:0]    current_q, current_d;
    logic                 valid_q, valid_d;
    logic                 osat_q, osat_d;
    logic                 overrun_q, overrun_d;

    logic [WEIGHT_W-1:0]  weight_q [N_PRE];

    // Weight file. Writes land at the edge, so a scan read of the same address in the
    // same cycle still sees the old value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N_PRE; i++) begin
                weight_q[i] <= '0;
            end
        end else if (i_w_we && (32'(i_w_addr) < N_PRE)) begin
            weight_q[i_w_addr] <= i_w_data;
        end
    end

    logic [DATA_W:0]      sum;
    logic                 add_en;
    logic                 last_idx;
    logic [DATA_W-1:0]    acc_next;
    logic                 sat_next;
    logic [DATA_W-1:0]    decay_val;
    logic [DATA_W-1:0]    start_acc;

    always_comb begin
        add_en    = spikes_q[idx_q];
        last_idx  = (idx_q == IDX_W'(N_PRE - 1));
        // One extra bit catches the carry out that signals saturation.
        sum       = {1'b0, acc_q} + {{(DATA_W + 1 - WEIGHT_W){1'b0}}, weight_q[idx_q]};
        acc_next  = acc_q;
        sat_next  = sat_q;
        if (add_en) begin
            acc_next = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
            sat_next = sat_q | sum[DATA_W];
        end
        // The decayed value never exceeds prev, so it cannot overflow.
        decay_val = current_q - (current_q >> TAU_SHIFT);
        start_acc = DECAY_EN ? decay_val : '0;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        spikes_d  = spikes_q;
        acc_d     = acc_q;
        sat_d     = sat_q;
        current_d = current_q;
        valid_d   = valid_q;
        osat_d    = osat_q;
        overrun_d = overrun_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_step_start) begin
                    spikes_d = i_pre_spikes;
                    idx_d    = '0;
                    acc_d    = start_acc;
                    sat_d    = 1'b0;
                    state_d  = S_SCAN;
                end
            end
            S_SCAN: begin
                if (i_step_start) begin
                    overrun_d = 1'b1;
                end
                acc_d = acc_next;
                sat_d = sat_next;
                idx_d = idx_q + 1'b1;
                if (last_idx) begin
                    // Publish the sum including the final synapse on the DONE entry edge.
                    current_d = acc_next;
                    osat_d    = sat_next;
                    valid_d   = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (i_step_start) begin
                    overrun_d = 1'b1;
                end
                if (valid_q && i_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            spikes_q  <= '0;
            acc_q     <= '0;
            sat_q     <= 1'b0;
            current_q <= '0;
            valid_q   <= 1'b0;
            osat_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            spikes_q  <= spikes_d;
            acc_q     <= acc_d;
            sat_q     <= sat_d;
            current_q <= current_d;
            valid_q   <= valid_d;
            osat_q    <= osat_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_current = current_q;
    assign o_valid   = valid_q;
    assign o_busy    = (state_q != S_IDLE);
    assign o_sat     = osat_q;
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_synapse_current_accum.sv
// tb/tb_synapse_current_accum.sv - directed self-checking bench for synapse_current_accum

module tb_synapse_current_accum;

`ifdef SYN_DECAY_EN
    localparam bit DECAY = 1'b1;
`else
    localparam bit DECAY = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_step_start = 1'b0;
    logic [7:0]  i_pre_spikes = '0;
    logic        i_w_we = 1'b0;
    logic [2:0]  i_w_addr = '0;
    logic [15:0] i_w_data = '0;
    logic        i_ready = 1'b0;

    logic [31:0] o_current;
    logic        o_valid, o_busy, o_sat, o_overrun;
    logic [15:0] c16;
    logic        v16, b16, s16, ov16;

    always #5 i_clk = ~i_clk;

    synapse_current_accum #(.N_PRE(8), .WEIGHT_W(16), .DATA_W(32), .TAU_SHIFT(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_step_start(i_step_start), .i_pre_spikes(i_pre_spikes),
        .i_w_we(i_w_we), .i_w_addr(i_w_addr), .i_w_data(i_w_data),
        .o_current(o_current), .o_valid(o_valid), .i_ready(i_ready),
        .o_busy(o_busy), .o_sat(o_sat), .o_overrun(o_overrun)
    );

    synapse_current_accum #(.N_PRE(8), .WEIGHT_W(16), .DATA_W(16), .TAU_SHIFT(4)) dut16 (
        .i_clk(i_clk), .i_rst(i_rst), .i_step_start(i_step_start), .i_pre_spikes(i_pre_spikes),
        .i_w_we(i_w_we), .i_w_addr(i_w_addr), .i_w_data(i_w_data),
        .o_current(c16), .o_valid(v16), .i_ready(i_ready),
        .o_busy(b16), .o_sat(s16), .o_overrun(ov16)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  spikes;
        logic [31:0] exp_current;
        logic        exp_sat;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic write_w(input logic [2:0] a, input logic [15:0] d);
        i_w_we = 1'b1;
        i_w_addr = a;
        i_w_data = d;
        tick();
        i_w_we = 1'b0;
    endtask

    // Reset, then load w[i] = 10*(i+1).
    task automatic fresh();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            write_w(3'(i), 16'(10 * (i + 1)));
        end
    endtask

    task automatic start_step(input logic [7:0] sp);
        i_pre_spikes = sp;
        i_step_start = 1'b1;
        tick();
        i_step_start = 1'b0;
    endtask

    // Returns the number of edges from the start edge until o_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!o_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_step(input string name, input logic [7:0] sp,
                           input logic [31:0] exp_cur, input logic exp_sat);
        int lat;
        i_ready = 1'b1;
        start_step(sp);
        wait_valid(lat);
        check({name, "_latency"}, 64'(lat), 64'd9);
        check({name, "_current"}, 64'(o_current), 64'(exp_cur));
        check({name, "_sat"}, 64'(o_sat), 64'(exp_sat));
        tick();
        check({name, "_valid_drop"}, 64'(o_valid), 64'd0);
        check({name, "_idle"}, 64'(o_busy), 64'd0);
    endtask

    initial begin
        int lat;

        tbl[0] = '{8'b1010_0101, 32'd180, 1'b0};
        tbl[1] = '{8'h00,        32'd0,   1'b0};
        tbl[2] = '{8'hFF,        32'd360, 1'b0};
        tbl[3] = '{8'h80,        32'd80,  1'b0};
        tbl[4] = '{8'h01,        32'd10,  1'b0};
        tbl[5] = '{8'h5A,        32'd180, 1'b0};

        // Reset state
        tick();
        tick();
        check("rst_current", 64'(o_current), 64'd0);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_sat", 64'(o_sat), 64'd0);
        check("rst_overrun", 64'(o_overrun), 64'd0);

        // Table-driven timesteps over the base weight set
        fresh();
        for (int i = 0; i < 6; i++) begin
            if (DECAY) fresh();
            do_step($sformatf("tbl%0d", i), tbl[i].spikes, tbl[i].exp_current, tbl[i].exp_sat);
        end

        // Saturation at DATA_W=16, then a zero step clears o_sat
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        for (int i = 0; i < 8; i++) write_w(3'(i), 16'hFFFF);
        i_ready = 1'b1;
        start_step(8'hFF);
        wait_valid(lat);
        check("sat_latency", 64'(lat), 64'd9);
        check("sat_dut32_current", 64'(o_current), 64'd524280);
        check("sat_dut32_sat", 64'(o_sat), 64'd0);
        check("sat_dut16_valid", 64'(v16), 64'd1);
        check("sat_dut16_current", 64'(c16), 64'hFFFF);
        check("sat_dut16_sat", 64'(s16), 64'd1);
        tick();
        start_step(8'h00);
        wait_valid(lat);
        check("zero_latency", 64'(lat), 64'd9);
        check("zero_dut16_current", 64'(c16), DECAY ? 64'hF000 : 64'd0);
        check("zero_dut16_sat", 64'(s16), 64'd0);
        check("zero_dut32_current", 64'(o_current), DECAY ? 64'd491513 : 64'd0);
        tick();

        // Backpressure with a start during DONE
        fresh();
        i_ready = 1'b0;
        start_step(8'b1010_0101);
        wait_valid(lat);
        check("bp_latency", 64'(lat), 64'd9);
        check("bp_overrun_before", 64'(o_overrun), 64'd0);
        for (int c = 10; c < 29; c++) begin
            i_step_start = (c == 12);
            tick();
        end
        i_step_start = 1'b0;
        check("bp_valid_held", 64'(o_valid), 64'd1);
        check("bp_current_held", 64'(o_current), 64'd180);
        check("bp_overrun", 64'(o_overrun), 64'd1);
        check("bp_busy", 64'(o_busy), 64'd1);
        i_ready = 1'b1;
        tick();
        check("bp_valid_drop", 64'(o_valid), 64'd0);
        check("bp_idle", 64'(o_busy), 64'd0);
        check("bp_current_kept", 64'(o_current), 64'd180);

        // Weight writes during SCAN: w[3] rewritten while being read, w[6] before its read
        fresh();
        i_ready = 1'b1;
        start_step(8'h48);
        tick();
        tick();
        tick();
        i_w_we = 1'b1; i_w_addr = 3'd3; i_w_data = 16'd999;
        tick();
        i_w_addr = 3'd6; i_w_data = 16'd5;
        tick();
        i_w_we = 1'b0;
        wait_valid(lat);
        check("wscan_current", 64'(o_current), 64'd45);
        tick();
        do_step("wscan_next", 8'h08, DECAY ? 32'd1042 : 32'd999, 1'b0);

        // Start and weight write in the same cycle
        fresh();
        i_w_we = 1'b1; i_w_addr = 3'd0; i_w_data = 16'd7;
        start_step(8'h01);
        i_w_we = 1'b0;
        wait_valid(lat);
        check("wstart_latency", 64'(lat), 64'd9);
        check("wstart_current", 64'(o_current), 64'd7);
        tick();

        // Reset in the middle of a scan
        fresh();
        do_step("pre_rst", 8'b1010_0101, 32'd180, 1'b0);
        start_step(8'hFF);
        i_step_start = 1'b1;
        tick();
        i_step_start = 1'b0;
        tick();
        tick();
        tick();
        check("mid_overrun", 64'(o_overrun), 64'd1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("mrst_current", 64'(o_current), 64'd0);
        check("mrst_valid", 64'(o_valid), 64'd0);
        check("mrst_busy", 64'(o_busy), 64'd0);
        check("mrst_sat", 64'(o_sat), 64'd0);
        check("mrst_overrun", 64'(o_overrun), 64'd0);
        do_step("post_rst", 8'hFF, 32'd0, 1'b0);

`ifdef SYN_DECAY_EN
        fresh();
        do_step("decay1", 8'hC1, 32'd160, 1'b0);
        do_step("decay2", 8'h00, 32'd150, 1'b0);
        write_w(3'd0, 16'd10);
        do_step("decay3", 8'h01, 32'd151, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
